// File: rtl/serial_link_peer_pkg.sv
// Shared definitions for the serial link peer: TX FSM states, UART line level, frame sizes.
// Optional build macro SERIAL_PARITY_EN (used by serial_link_peer) adds an even-parity bit.
package serial_link_peer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam logic UART_IDLE_LVL = 1'b1;
    localparam int   DATA_BITS     = 8;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/serial_link_peer_byte_fifo.sv
// First-word-fall-through byte FIFO with extra-MSB pointers; used for both link directions.
module byte_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [7:0]          mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic                do_push;
    logic                do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);

    // A pop on a full FIFO frees the slot the same-cycle push lands in.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign dout = empty ? 8'h00 : mem[rd_ptr[DEPTH_LOG2-1:0]];

    always_ff @(posedge clock) begin
        if (do_push)
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/serial_link_peer.sv
// Far end of the processor byte-serial port: outbound FIFO + UART transmitter, inbound host FIFO.
// Define SERIAL_PARITY_EN for an even-parity bit between data and stop (8E1 instead of 8N1).
module serial_link_peer
    import serial_link_peer_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int BAUD_DIV   = 868
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       proc_wren_in,
    input  logic [7:0] proc_data_in,
    output logic       proc_ready_out,
    input  logic       proc_rden_in,
    output logic [7:0] proc_data_out,
    output logic       proc_valid_out,
    input  logic [7:0] host_data_in,
    input  logic       host_valid_in,
    output logic       host_ready_out,
    output logic       tx_out,
    output logic       tx_busy_out,
    output logic       overflow_out
);

    localparam int             CW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0]  BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [2:0]     LAST_BIT  = 3'(DATA_BITS - 1);

    logic       out_full;
    logic       out_empty;
    logic [7:0] out_head;
    logic       in_full;
    logic       in_empty;
    logic       tx_pop;

    tx_state_t  state;
    logic [CW-1:0] baud;
    logic [2:0] bit_idx;
    logic [7:0] shift;
`ifdef SERIAL_PARITY_EN
    logic       parity;
`endif

    byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_out_fifo (
        .clock (clock),
        .reset (reset),
        .push  (proc_wren_in),
        .pop   (tx_pop),
        .din   (proc_data_in),
        .dout  (out_head),
        .full  (out_full),
        .empty (out_empty)
    );

    // Host bytes offered while full are taken only if the processor pops in the same cycle.
    byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_in_fifo (
        .clock (clock),
        .reset (reset),
        .push  (host_valid_in & (host_ready_out | proc_rden_in)),
        .pop   (proc_rden_in),
        .din   (host_data_in),
        .dout  (proc_data_out),
        .full  (in_full),
        .empty (in_empty)
    );

    assign proc_ready_out = ~out_full;
    assign proc_valid_out = ~in_empty;
    assign host_ready_out = ~in_full;

    // Frames are fetched from IDLE or straight out of the last STOP clock for back-to-back sending.
    assign tx_pop = ~out_empty &
                    ((state == ST_IDLE) || ((state == ST_STOP) && (baud == '0)));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            baud        <= '0;
            bit_idx     <= '0;
            shift       <= '0;
`ifdef SERIAL_PARITY_EN
            parity      <= 1'b0;
`endif
            tx_out      <= UART_IDLE_LVL;
            tx_busy_out <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_STOP: begin
                    if (state == ST_STOP && baud != '0) begin
                        baud <= baud - 1'b1;
                    end else if (tx_pop) begin
                        shift       <= out_head;
`ifdef SERIAL_PARITY_EN
                        parity      <= even_parity(out_head);
`endif
                        baud        <= BAUD_LAST;
                        state       <= ST_START;
                        tx_out      <= ~UART_IDLE_LVL;
                        tx_busy_out <= 1'b1;
                    end else begin
                        state       <= ST_IDLE;
                        tx_out      <= UART_IDLE_LVL;
                        tx_busy_out <= 1'b0;
                    end
                end
                ST_START: begin
                    if (baud == '0) begin
                        tx_out  <= shift[0];
                        shift   <= shift >> 1;
                        bit_idx <= '0;
                        baud    <= BAUD_LAST;
                        state   <= ST_DATA;
                    end else begin
                        baud <= baud - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (baud == '0) begin
                        baud <= BAUD_LAST;
                        if (bit_idx == LAST_BIT) begin
`ifdef SERIAL_PARITY_EN
                            state  <= ST_PARITY;
                            tx_out <= parity;
`else
                            state  <= ST_STOP;
                            tx_out <= UART_IDLE_LVL;
`endif
                        end else begin
                            tx_out  <= shift[0];
                            shift   <= shift >> 1;
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud <= baud - 1'b1;
                    end
                end
`ifdef SERIAL_PARITY_EN
                ST_PARITY: begin
                    if (baud == '0) begin
                        baud   <= BAUD_LAST;
                        state  <= ST_STOP;
                        tx_out <= UART_IDLE_LVL;
                    end else begin
                        baud <= baud - 1'b1;
                    end
                end
`endif
                default: begin
                    state       <= ST_IDLE;
                    tx_out      <= UART_IDLE_LVL;
                    tx_busy_out <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            overflow_out <= 1'b0;
        else if (proc_wren_in & out_full & ~tx_pop)
            overflow_out <= 1'b1;
    end

endmodule
